// File: rtl/seg7_pkg.sv
// Shared glyph table, frame FSM states and digit count for the 7-segment encoder/decoder pair.
package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   // Active-low gfedcba patterns for hex 0..F
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [6:0] BLANK = 7'h7F;

   typedef enum logic {
      COLLECT = 1'b0,
      PUBLISH = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_scan_to_bin_if.sv
// Display bus plus recovered-frame outputs; DP lines exist only when SEG7_DP_EN is defined.
interface seg7_scan_to_bin_if;

   // oValid is a single-cycle strobe with no back-pressure: oDig/oErr/oDp are
   // valid in that cycle and hold until the next strobe.
   logic [6:0]  iSeg;
   logic [5:0]  iDigEn;
   logic [23:0] oDig;
   logic        oValid;
   logic [5:0]  oErr;
   logic        oStale;
`ifdef SEG7_DP_EN
   logic        iDp;
   logic [5:0]  oDp;

   modport master (output iSeg, iDigEn, iDp, input oDig, oValid, oErr, oStale, oDp);
   modport slave  (input iSeg, iDigEn, iDp, output oDig, oValid, oErr, oStale, oDp);
`else
   modport master (output iSeg, iDigEn, input oDig, oValid, oErr, oStale);
   modport slave  (input iSeg, iDigEn, output oDig, oValid, oErr, oStale);
`endif

endinterface

// File: rtl/seg7_to_bin.sv
// Combinational glyph decoder: 7-bit active-low pattern to nibble, err set for non-hex patterns.
module seg7_to_bin
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       err
);

   always_comb begin
      nibble = '0;
      err    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (seg == GLYPH[i]) begin
            nibble = 4'(i);
            err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_to_bin.sv
// Recovers a 24-bit value from a scanned six-digit 7-segment bus.
// Optional decimal-point capture is built when SEG7_DP_EN is defined.
module seg7_scan_to_bin
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                iClk,
   input  logic                iRst_n,
   seg7_scan_to_bin_if.slave   bus,
   output state_t              fsm_state
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CAP_AT  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_PRE   = TW'(TIMEOUT_CYCLES - 1);

   logic [6:0]            seg_s1, seg_s2, seg_p;
   logic [NUM_DIGITS-1:0] en_s1, en_s2, en_p;
   logic [CW-1:0]         stab_cnt;
   logic                  one_hot, changed, capture;
   logic [NUM_DIGITS-1:0] cap_mask, seen;
   logic [3:0]            dec_nib;
   logic                  dec_err;
   logic [NUM_DIGITS-1:0][3:0] shadow_nib, dig_q;
   logic [NUM_DIGITS-1:0] shadow_err, err_q;
   logic                  valid_q, stale_q, publish;
   logic [TW-1:0]         tcnt;
   state_t                state, state_n;
   logic                  dp_changed;

   // seg_p/en_p hold the previous synchronized sample for change detection
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         seg_s1 <= BLANK;
         seg_s2 <= BLANK;
         seg_p  <= BLANK;
         en_s1  <= '0;
         en_s2  <= '0;
         en_p   <= '0;
      end else begin
         seg_s1 <= bus.iSeg;
         seg_s2 <= seg_s1;
         seg_p  <= seg_s2;
         en_s1  <= bus.iDigEn;
         en_s2  <= en_s1;
         en_p   <= en_s2;
      end
   end

`ifdef SEG7_DP_EN
   logic                  dp_s1, dp_s2, dp_p;
   logic [NUM_DIGITS-1:0] shadow_dp, dp_q;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         dp_s1     <= 1'b1;
         dp_s2     <= 1'b1;
         dp_p      <= 1'b1;
         shadow_dp <= '0;
         dp_q      <= '0;
      end else begin
         dp_s1 <= bus.iDp;
         dp_s2 <= dp_s1;
         dp_p  <= dp_s2;
         if (publish) dp_q <= shadow_dp;
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (cap_mask[n]) shadow_dp[n] <= ~dp_s2;
         end
      end
   end

   assign dp_changed = (dp_s2 != dp_p);
   assign bus.oDp    = dp_q;
`else
   assign dp_changed = 1'b0;
`endif

   assign one_hot  = (en_s2 != '0) && ((en_s2 & (en_s2 - 6'd1)) == '0);
   assign changed  = (seg_s2 != seg_p) || (en_s2 != en_p) || dp_changed;
   assign capture  = one_hot && !changed && (stab_cnt == CAP_AT);
   assign cap_mask = capture ? en_s2 : '0;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stab_cnt <= '0;
      end else if (changed || !one_hot) begin
         stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
         stab_cnt <= stab_cnt + 1'b1;
      end
   end

   seg7_to_bin u_dec (
      .seg    (seg_s2),
      .nibble (dec_nib),
      .err    (dec_err)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= COLLECT;
      else         state <= state_n;
   end

   // Entering PUBLISH on the final capture itself keeps capture-to-oValid at one cycle
   always_comb begin
      state_n = state;
      publish = 1'b0;
      case (state)
         COLLECT: if ((seen | cap_mask) == '1) state_n = PUBLISH;
         PUBLISH: begin
            publish = 1'b1;
            state_n = COLLECT;
         end
         default: state_n = COLLECT;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         shadow_nib <= '0;
         shadow_err <= '0;
         seen       <= '0;
         dig_q      <= '0;
         err_q      <= '0;
         valid_q    <= 1'b0;
         stale_q    <= 1'b0;
         tcnt       <= '0;
      end else begin
         valid_q <= publish;
         seen    <= (publish ? '0 : seen) | cap_mask;
         if (publish) begin
            dig_q <= shadow_nib;
            err_q <= shadow_err;
         end
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (cap_mask[n]) begin
               shadow_nib[n] <= dec_nib;
               shadow_err[n] <= dec_err;
            end
         end
         if (publish) begin
            tcnt    <= '0;
            stale_q <= 1'b0;
         end else if (state == COLLECT && tcnt != T_MAX) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == T_PRE) stale_q <= 1'b1;
         end
      end
   end

   assign bus.oDig   = dig_q;
   assign bus.oErr   = err_q;
   assign bus.oValid = valid_q;
   assign bus.oStale = stale_q;
   assign fsm_state  = state;

endmodule

// File: tb/tb_seg7_scan_to_bin.sv
// Bench for seg7_scan_to_bin: vector table of scans plus hand sequences for stale, bad strobe,
// reset mid-frame and (with SEG7_DP_EN) decimal-point capture.
module tb_seg7_scan_to_bin;
   import seg7_pkg::*;

   localparam int S = 16;
   localparam int T = 2000;
   localparam int W = 36;
   localparam int NV = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_to_bin_if bus ();
   state_t fsm_state;

   seg7_scan_to_bin #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .iClk      (clk),
      .iRst_n    (rst_n),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   typedef struct {
      logic [5:0][6:0] seg;
      int              dwell;
      bit              exp_frame;
      logic [23:0]     dig;
      logic [5:0]      err;
   } vec_t;

   logic [6:0] tg [16];
   vec_t       vecs [NV];
   logic [W-1:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int n_valid = 0;
   int cyc = 0;
   int valid_cyc = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] dut_word();
`ifdef SEG7_DP_EN
      return {bus.oDp, bus.oErr, bus.oDig};
`else
      return {6'h00, bus.oErr, bus.oDig};
`endif
   endfunction

   // Scoreboard: every oValid pops one expected frame
   always @(negedge clk) begin
      if (bus.oValid === 1'b1) begin
         n_valid++;
         valid_cyc = cyc;
         check("valid_gap", 64'(prev_valid), 64'h0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got frame %0h, want no oValid", dut_word());
         end else begin
            check("frame", 64'(dut_word()), 64'(exp_q.pop_front()));
         end
      end
      prev_valid = bus.oValid;
   end

   task automatic idle(input int n);
      bus.iDigEn = '0;
      bus.iSeg   = 7'h7F;
`ifdef SEG7_DP_EN
      bus.iDp    = 1'b1;
`endif
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_digit(input int d, input logic [6:0] pat, input logic dp_n, input int dwell);
      bus.iDigEn = 6'(1 << d);
      bus.iSeg   = pat;
`ifdef SEG7_DP_EN
      bus.iDp    = dp_n;
`else
      if (dp_n !== 1'b1) $display("note: dp ignored in this build");
`endif
      repeat (dwell) @(negedge clk);
   endtask

   task automatic scan(input logic [5:0][6:0] segs, input int dwell, input logic [5:0] dp_mask);
      for (int d = 0; d < 6; d++) drive_digit(d, segs[d], ~dp_mask[d], dwell);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_frame"}, 64'(dut_word()), 64'h0);
      check({tag, "_valid_stale"}, {62'h0, bus.oValid, bus.oStale}, 64'h0);
      check({tag, "_fsm"}, 64'(fsm_state), 64'(COLLECT));
   endtask

   initial begin
      int base;
      int k;
      tg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      vecs[0] = '{seg: {tg[6], tg[5], tg[4], tg[3], tg[2], tg[1]}, dwell: 40,
                  exp_frame: 1'b1, dig: 24'h654321, err: 6'h00};
      vecs[1] = '{seg: {tg[6], tg[5], tg[4], 7'h7F, tg[2], tg[1]}, dwell: 40,
                  exp_frame: 1'b1, dig: 24'h654021, err: 6'h04};
      vecs[2] = '{seg: {tg[11], tg[10], tg[9], tg[8], tg[7], tg[0]}, dwell: 30,
                  exp_frame: 1'b1, dig: 24'hBA9870, err: 6'h00};
      vecs[3] = '{seg: {7'h7F, tg[15], tg[14], tg[13], tg[12], 7'h55}, dwell: 25,
                  exp_frame: 1'b1, dig: 24'h0FEDC0, err: 6'h21};
      vecs[4] = '{seg: {tg[3], tg[3], tg[3], tg[3], tg[3], tg[3]}, dwell: S + 1,
                  exp_frame: 1'b1, dig: 24'h333333, err: 6'h00};
      vecs[5] = '{seg: {tg[9], tg[9], tg[9], tg[9], tg[9], tg[9]}, dwell: S,
                  exp_frame: 1'b0, dig: 24'h0, err: 6'h00};

      bus.iSeg   = 7'h7F;
      bus.iDigEn = '0;
`ifdef SEG7_DP_EN
      bus.iDp    = 1'b1;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      idle(4);

      for (int v = 0; v < NV; v++) begin
         base = n_valid;
         if (vecs[v].exp_frame) exp_q.push_back({6'h00, vecs[v].err, vecs[v].dig});
         scan(vecs[v].seg, vecs[v].dwell, 6'h00);
         idle(8);
         check($sformatf("vec%0d_frames", v), 64'(n_valid - base), vecs[v].exp_frame ? 64'd1 : 64'd0);
      end

      // Short dwells never capture; oStale rises exactly T cycles after the last oValid
      base = n_valid;
      for (int t = 0; t < 3 * T; t++) begin
         drive_digit((t / 10) % 6, tg[(t / 10) % 6], 1'b1, 1);
         k = cyc - valid_cyc;
         if (k == T - 1) check("stale_before", 64'(bus.oStale), 64'h0);
         if (k == T) check("stale_at", 64'(bus.oStale), 64'h1);
         if (k >= T + 20) break;
      end
      check("stale_held", 64'(bus.oStale), 64'h1);
      check("short_dwell_frames", 64'(n_valid - base), 64'd0);
      idle(4);
      base = n_valid;
      exp_q.push_back({6'h00, 6'h00, 24'h654321});
      scan(vecs[0].seg, 40, 6'h00);
      idle(8);
      check("stale_cleared", 64'(bus.oStale), 64'h0);
      check("recover_frames", 64'(n_valid - base), 64'd1);

      // Two strobe bits at once must be ignored
      base = n_valid;
      bus.iDigEn = 6'h03;
      bus.iSeg   = tg[5];
      repeat (100) @(negedge clk);
      exp_q.push_back({6'h00, 6'h00, 24'hFEDCBA});
      scan({tg[15], tg[14], tg[13], tg[12], tg[11], tg[10]}, 40, 6'h00);
      idle(8);
      check("multi_strobe_frames", 64'(n_valid - base), 64'd1);

      // Reset after three captures discards the partial frame
      base = n_valid;
      for (int d = 0; d < 3; d++) drive_digit(d, tg[8], 1'b1, 40);
      idle(1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("midreset");
      rst_n = 1'b1;
      idle(4);
      check("partial_frames", 64'(n_valid - base), 64'd0);
      exp_q.push_back({6'h00, 6'h00, 24'h888888});
      scan({tg[8], tg[8], tg[8], tg[8], tg[8], tg[8]}, 40, 6'h00);
      idle(8);
      check("post_reset_frames", 64'(n_valid - base), 64'd1);

`ifdef SEG7_DP_EN
      base = n_valid;
      exp_q.push_back({6'h02, 6'h00, 24'h654321});
      scan(vecs[0].seg, 40, 6'h02);
      idle(8);
      check("dp_frames", 64'(n_valid - base), 64'd1);
`endif

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg7_scan_to_bin.md
# seg7_scan_to_bin

Recovers a 24-bit hex value from an externally driven, time-multiplexed six-digit 7-segment display bus. It is the inverse of the team's binary-to-6×7-segment encoder, and reads a front-panel display of brewing equipment so its value can be reused in logic. Inputs are synchronized, and each digit strobe is qualified by a stability count. Segment patterns are decoded back to nibbles, and a complete frame is published with a one-cycle valid pulse.

## Interface
- `STABLE_CYCLES`, default 16: consecutive cycles a digit strobe and pattern must hold before capture (≥2).
- `TIMEOUT_CYCLES`, default 1048576: cycles without a completed frame before `oStale` asserts.
- `iClk` input 1: system clock.
- `iRst_n` input 1: reset, asynchronous, active-low.
- `iSeg` input 7: segment lines, active-low, bit0=a … bit6=g; asynchronous to `iClk`.
- `iDigEn` input 6: digit strobes, active-high, intended one-hot; bit n selects digit n (n=0 least significant).
- `oDig` output 24: last complete frame, digit n in bits [4n+3:4n].
- `oValid` output 1: one-cycle pulse when `oDig`/`oErr` update.
- `oErr` output 6: per digit, set if the captured pattern was not a legal hex glyph.
- `oStale` output 1: no frame completed within `TIMEOUT_CYCLES`.
- `iDp` input 1 and `oDp` output 6: only with `SEG7_DP_EN`; `iDp` is active-low.

## Operation
- `iSeg` and `iDigEn` each pass through a 2-FF synchronizer. All logic below uses the synchronized values.
- Qualifier:
  - The counter resets to 0 whenever `iDigEn` or `iSeg` differs from the previous cycle.
  - It also resets when `iDigEn` is zero or not one-hot.
  - Otherwise it increments and saturates at `STABLE_CYCLES`.
- Capture: on the cycle the counter reaches `STABLE_CYCLES-1`, the decoded nibble and error bit are written into the shadow slot for the active digit, and the digit's bit is set in `seen`. Each strobe activation produces one capture. A later activation of the same digit in the same frame overwrites its slot.
- Decode table (active-low, gfedcba):
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h
  - 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh
  - Any other pattern, including blank 7Fh, decodes to 0 and sets the error bit.
- Frame FSM:
  - COLLECT: runs until `seen`==3Fh.
  - PUBLISH: one cycle. Copies the shadow slots to `oDig`/`oErr`, pulses `oValid`, clears `seen` and the timeout counter, then returns to COLLECT.
  - A capture arriving during PUBLISH is recorded into the new frame (shadow and `seen` set after clear).
- Timeout counter:
  - Increments in COLLECT and saturates.
  - `oStale` sets when the count reaches `TIMEOUT_CYCLES`.
  - `oStale` clears on the next `oValid`.
- Reset values: `oDig`=0, `oErr`=0, `oValid`=0, `oStale`=0, `oDp`=0. FSM=COLLECT, `seen`=0, counters=0, synchronizers=all-inactive (`iSeg` 7Fh, `iDigEn` 0).
- Reset mid-frame discards partial captures. No `oValid` is issued for that frame.

## Timing
- Input to synchronized value: 2 cycles.
- Strobe edge to capture: 2 + `STABLE_CYCLES` cycles when the input is clean.
- Final capture to `oValid`: 1 cycle. `oDig` is valid in the same cycle as `oValid` and holds until the next pulse.
- `oValid` is never asserted on two consecutive cycles.
- Strobe dwell shorter than `STABLE_CYCLES`+1 cycles never captures.

## Configuration
- `SEG7_DP_EN`:
  - Defined: `iDp` is synchronized and qualified alongside `iSeg`, captured per digit, and published on `oDp` (active-high, bit n = digit n) with `oValid`. A change on `iDp` also resets the stability counter.
  - Undefined: the `iDp` and `oDp` ports are absent and no DP logic is built.

## Structure
- Package `seg7_pkg`: the 16 glyph constants, the blank pattern 7Fh, the FSM state enum {COLLECT, PUBLISH}, and the digit count 6.
- Sub-module `seg7_to_bin`: combinational 7-bit to {nibble, err} decoder. It shares the glyph constants with the encoder so both directions stay consistent.

## Test plan
- Scan digits 0–5 with patterns for 1,2,3,4,5,6, 40 cycles each → one `oValid`; `oDig`=654321h, `oErr`=0.
- Same scan with digit 2 blank (7Fh) → `oDig`=654021h, `oErr`=04h.
- Dwell 10 cycles per digit (below `STABLE_CYCLES`+1) → no capture, no `oValid`; `oStale` asserts after `TIMEOUT_CYCLES`, then clears on the first good frame.
- Strobe 03h (two bits) held 100 cycles, then a proper scan of A,b,C,d,E,F → only the proper scan captured; `oDig`=FEDCBAh.
- Assert `iRst_n`=0 after 3 digits captured, release, then a full scan of 8s → first `oValid` shows 888888h; no `oValid` for the partial frame.
- With `SEG7_DP_EN`, `iDp`=0 on digit 1 only → `oDp`=02h.
